// File: rtl/i281_pkg.sv
// rtl/i281_pkg.sv - shared opcodes, one-hot indices, flag bits and run-controller states
package i281_pkg;

    localparam logic [3:0] OP_NOOP   = 4'b0000;
    localparam logic [3:0] OP_INPUT  = 4'b0001;
    localparam logic [3:0] OP_MOVE   = 4'b0010;
    localparam logic [3:0] OP_LOADI  = 4'b0011;
    localparam logic [3:0] OP_ADD    = 4'b0100;
    localparam logic [3:0] OP_ADDI   = 4'b0101;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_SUBI   = 4'b0111;
    localparam logic [3:0] OP_LOAD   = 4'b1000;
    localparam logic [3:0] OP_LOADF  = 4'b1001;
    localparam logic [3:0] OP_STORE  = 4'b1010;
    localparam logic [3:0] OP_STOREF = 4'b1011;
    localparam logic [3:0] OP_SHIFT  = 4'b1100;
    localparam logic [3:0] OP_CMP    = 4'b1101;
    localparam logic [3:0] OP_JUMP   = 4'b1110;
    localparam logic [3:0] OP_BRANCH = 4'b1111;

    localparam int IDX_NOOP    = 0;
    localparam int IDX_INPUTC  = 1;
    localparam int IDX_INPUTCF = 2;
    localparam int IDX_INPUTD  = 3;
    localparam int IDX_INPUTDF = 4;
    localparam int IDX_MOVE    = 5;
    localparam int IDX_LOADI   = 6;
    localparam int IDX_ADD     = 7;
    localparam int IDX_ADDI    = 8;
    localparam int IDX_SUB     = 9;
    localparam int IDX_SUBI    = 10;
    localparam int IDX_LOAD    = 11;
    localparam int IDX_LOADF   = 12;
    localparam int IDX_STORE   = 13;
    localparam int IDX_STOREF  = 14;
    localparam int IDX_SHIFTL  = 15;
    localparam int IDX_SHIFTR  = 16;
    localparam int IDX_CMP     = 17;
    localparam int IDX_JUMP    = 18;
    localparam int IDX_BRE     = 19;
    localparam int IDX_BRNE    = 20;
    localparam int IDX_BRG     = 21;
    localparam int IDX_BRGE    = 22;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } run_state_t;

endpackage

// File: rtl/opcode_onehot.sv
// rtl/opcode_onehot.sv - combinational decode of a 16-bit i281 word into the 27-bit opcode bus
module opcode_onehot
    import i281_pkg::*;
(
    input  logic [15:0] i_word,
    output logic [26:0] o_opcode
);

    logic [4:0]  w_idx;
    logic [22:0] w_onehot;

    // Families share a base index and add their sub-code field
    always_comb begin
        w_idx = 5'(IDX_NOOP);
        case (i_word[15:12])
            OP_NOOP:   w_idx = 5'(IDX_NOOP);
            OP_INPUT:  w_idx = 5'(IDX_INPUTC) + {3'b000, i_word[9:8]};
            OP_MOVE:   w_idx = 5'(IDX_MOVE);
            OP_LOADI:  w_idx = 5'(IDX_LOADI);
            OP_ADD:    w_idx = 5'(IDX_ADD);
            OP_ADDI:   w_idx = 5'(IDX_ADDI);
            OP_SUB:    w_idx = 5'(IDX_SUB);
            OP_SUBI:   w_idx = 5'(IDX_SUBI);
            OP_LOAD:   w_idx = 5'(IDX_LOAD);
            OP_LOADF:  w_idx = 5'(IDX_LOADF);
            OP_STORE:  w_idx = 5'(IDX_STORE);
            OP_STOREF: w_idx = 5'(IDX_STOREF);
            OP_SHIFT:  w_idx = i_word[8] ? 5'(IDX_SHIFTR) : 5'(IDX_SHIFTL);
            OP_CMP:    w_idx = 5'(IDX_CMP);
            OP_JUMP:   w_idx = 5'(IDX_JUMP);
            OP_BRANCH: w_idx = 5'(IDX_BRE) + {3'b000, i_word[9:8]};
            default:   w_idx = 5'(IDX_NOOP);
        endcase
    end

    assign w_onehot = 23'd1 << w_idx;
    assign o_opcode = {i_word[11:10], i_word[9:8], w_onehot};

endmodule

// File: rtl/instr_decode_unit.sv
// rtl/instr_decode_unit.sv - IR, registered one-hot decode, flags register and run/step controller
// Define STEP_MODE_EN for the HALT/RUN/STEP controller; otherwise HALT/RUN only.
module instr_decode_unit
    import i281_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        step_mode,
    input  logic [15:0] instr_in,
    input  logic        ir_load,
    input  logic [3:0]  alu_flags,
    input  logic        flags_load,
    input  logic        instr_done,
    output logic [26:0] opcode_out,
    output logic [7:0]  imm_out,
    output logic [15:0] ir_out,
    output logic [3:0]  flags_reg,
    output logic        cpu_en
);

    logic [15:0]            r_ir;
    logic [26:0]            r_opcode;
    logic [3:0]             r_flags;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_cpu_en;
    run_state_t             r_state;
    run_state_t             w_state_next;
    logic [26:0]            w_decode;
    logic                   w_run_sync;

    opcode_onehot u_opcode_onehot (
        .i_word   (instr_in),
        .o_opcode (w_decode)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ir     <= 16'h0000;
            r_opcode <= 27'h0000001;
            r_flags  <= 4'h0;
        end else begin
            if (ir_load) begin
                r_ir     <= instr_in;
                r_opcode <= w_decode;
            end
            if (flags_load)
                r_flags <= alu_flags;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], run};
    end

    assign w_run_sync = r_sync[SYNC_STAGES-1];

`ifdef STEP_MODE_EN
    logic r_run_prev;
    logic w_run_rise;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_run_prev <= 1'b0;
        else
            r_run_prev <= w_run_sync;
    end

    assign w_run_rise = w_run_sync & ~r_run_prev;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HALT: begin
                if (!step_mode && w_run_sync)
                    w_state_next = ST_RUN;
                else if (step_mode && w_run_rise)
                    w_state_next = ST_STEP;
            end
            ST_RUN: begin
                if (instr_done && (!w_run_sync || step_mode))
                    w_state_next = ST_HALT;
            end
            ST_STEP: begin
                if (instr_done)
                    w_state_next = ST_HALT;
            end
            default: w_state_next = ST_HALT;
        endcase
    end
`else
    logic w_unused_step_mode;
    assign w_unused_step_mode = step_mode;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HALT: begin
                if (w_run_sync)
                    w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (instr_done && !w_run_sync)
                    w_state_next = ST_HALT;
            end
            default: w_state_next = ST_HALT;
        endcase
    end
`endif

    // cpu_en is decoded from the next state so it drops on the same edge that samples instr_done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_HALT;
            r_cpu_en <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cpu_en <= (w_state_next != ST_HALT);
        end
    end

    assign opcode_out = r_opcode;
    assign imm_out    = r_ir[7:0];
    assign ir_out     = r_ir;
    assign flags_reg  = r_flags;
    assign cpu_en     = r_cpu_en;

endmodule

// File: tb/tb_instr_decode_unit.sv
// tb/tb_instr_decode_unit.sv - directed self-checking bench for instr_decode_unit
module tb_instr_decode_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        step_mode;
    logic [15:0] instr_in;
    logic        ir_load;
    logic [3:0]  alu_flags;
    logic        flags_load;
    logic        instr_done;
    logic [26:0] opcode_out;
    logic [7:0]  imm_out;
    logic [15:0] ir_out;
    logic [3:0]  flags_reg;
    logic        cpu_en;

    int n_checks = 0;
    int n_errors = 0;

    int exp_idx [16][4] = '{
        '{0, 0, 0, 0},     '{1, 2, 3, 4},     '{5, 5, 5, 5},     '{6, 6, 6, 6},
        '{7, 7, 7, 7},     '{8, 8, 8, 8},     '{9, 9, 9, 9},     '{10, 10, 10, 10},
        '{11, 11, 11, 11}, '{12, 12, 12, 12}, '{13, 13, 13, 13}, '{14, 14, 14, 14},
        '{15, 16, 15, 16}, '{17, 17, 17, 17}, '{18, 18, 18, 18}, '{19, 20, 21, 22}
    };

    instr_decode_unit #(.SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .step_mode  (step_mode),
        .instr_in   (instr_in),
        .ir_load    (ir_load),
        .alu_flags  (alu_flags),
        .flags_load (flags_load),
        .instr_done (instr_done),
        .opcode_out (opcode_out),
        .imm_out    (imm_out),
        .ir_out     (ir_out),
        .flags_reg  (flags_reg),
        .cpu_en     (cpu_en)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic load_ir(input logic [15:0] word);
        instr_in = word;
        ir_load  = 1'b1;
        tick();
        ir_load  = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        logic [26:0] e;

        reset = 1'b1; run = 1'b0; step_mode = 1'b0; instr_in = 16'h0;
        ir_load = 1'b0; alu_flags = 4'h0; flags_load = 1'b0; instr_done = 1'b0;
        tick(2);
        reset = 1'b0;
        tick();

        check("rst_opcode", 32'(opcode_out), 32'h0000001);
        check("rst_flags",  32'(flags_reg),  32'h0);
        check("rst_cpu_en", 32'(cpu_en),     32'h0);
        check("rst_ir",     32'(ir_out),     32'h0);
        check("rst_imm",    32'(imm_out),    32'h0);

        load_ir(16'hF6AA);
        check("brg_opcode", 32'(opcode_out), 32'h3200000);
        check("brg_imm",    32'(imm_out),    32'hAA);
        check("brg_ir",     32'(ir_out),     32'hF6AA);

        for (int op = 0; op < 16; op++) begin
            for (int sub = 0; sub < 4; sub++) begin
                w = {4'(op), 2'b10, 2'(sub), 8'h5A};
                load_ir(w);
                e = {2'b10, 2'(sub), 23'd1 << exp_idx[op][sub]};
                check($sformatf("sweep_%h", w), 32'(opcode_out), 32'(e));
                check($sformatf("onehot_%h", w), 32'($countones(opcode_out[22:0])), 32'd1);
            end
        end

        load_ir(16'hC100);
        check("shiftr", 32'(opcode_out), 32'h0810000);

        alu_flags = 4'b0010; flags_load = 1'b1;
        tick();
        flags_load = 1'b0; alu_flags = 4'b1111;
        check("flags_load", 32'(flags_reg), 32'h2);
        tick();
        check("flags_hold", 32'(flags_reg), 32'h2);

`ifdef STEP_MODE_EN
        step_mode = 1'b1; run = 1'b1;
        tick(2);
        check("step_lat2", 32'(cpu_en), 32'h0);
        tick();
        check("step_lat3", 32'(cpu_en), 32'h1);
        run = 1'b0;
        tick(4);
        run = 1'b1;
        tick(3);
        run = 1'b0;
        tick(4);
        check("step_2nd_pulse", 32'(cpu_en), 32'h1);
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        check("step_done", 32'(cpu_en), 32'h0);
        tick(5);
        check("step_stay", 32'(cpu_en), 32'h0);
        step_mode = 1'b0;
`endif

        run = 1'b1;
        tick(2);
        check("run_lat2", 32'(cpu_en), 32'h0);
        tick();
        check("run_lat3", 32'(cpu_en), 32'h1);
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        check("run_done_hold", 32'(cpu_en), 32'h1);
        run = 1'b0;
        tick(5);
        check("run_drop_mid", 32'(cpu_en), 32'h1);
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        check("run_stop", 32'(cpu_en), 32'h0);
        tick(3);
        check("run_stay", 32'(cpu_en), 32'h0);

        run = 1'b1;
        tick(4);
        check("rerun", 32'(cpu_en), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_cpu_en", 32'(cpu_en),     32'h0);
        check("async_opcode", 32'(opcode_out), 32'h0000001);
        check("async_flags",  32'(flags_reg),  32'h0);
        check("async_ir",     32'(ir_out),     32'h0);
        @(negedge clock);
        reset = 1'b0; run = 1'b0;
        load_ir(16'h2400);
        check("post_rst_move", 32'(opcode_out), 32'h2000020);
        check("post_rst_cpu_en", 32'(cpu_en), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
